// File: rtl/peak_tournament_ctrl.sv
// Peak search over a 16-bin FFT frame: load bins, then run a 4-round
// pairwise tournament through an external registered magnitude comparator.
module peak_tournament_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        in_ready,
   output logic        cmp_en,
   output logic [31:0] cmp_data1,
   output logic [31:0] cmp_data2,
   output logic [3:0]  cmp_freq1,
   output logic [3:0]  cmp_freq2,
   input  logic [31:0] win_data,
   input  logic [3:0]  win_freq,
   output logic        peak_valid,
   output logic [31:0] peak_data,
   output logic [3:0]  peak_freq,
   output logic        busy
);

   typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [1:0]  rnd;
   logic [2:0]  pair;
   logic [3:0]  npairs;
   logic        accept;
   logic        last_pair;
   logic        last_cmp;
   logic [31:0] slot_data [16];
   logic [3:0]  slot_freq [16];

   assign accept    = in_valid && (state == LOAD);
   assign npairs    = 4'd8 >> rnd;
   assign last_pair = ({1'b0, pair} == (npairs - 4'd1));
   assign last_cmp  = last_pair && (rnd == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      cmp_en     = 1'b0;
      cmp_data1  = '0;
      cmp_data2  = '0;
      cmp_freq1  = '0;
      cmp_freq2  = '0;
      peak_valid = 1'b0;
      busy       = 1'b1;
      unique case (state)
         LOAD: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (in_valid && cnt == 4'd15) state_nxt = ISSUE;
         end
         ISSUE: begin
            cmp_en    = 1'b1;
            cmp_data1 = slot_data[{pair, 1'b0}];
            cmp_data2 = slot_data[{pair, 1'b1}];
            cmp_freq1 = slot_freq[{pair, 1'b0}];
            cmp_freq2 = slot_freq[{pair, 1'b1}];
            state_nxt = WAIT;
         end
         WAIT:    state_nxt = last_cmp ? DONE : ISSUE;
         DONE: begin
            peak_valid = 1'b1;
            state_nxt  = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // The final winner lands in slot 0 and the peak register together,
   // so the result is already stable during the DONE pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         rnd       <= '0;
         pair      <= '0;
         peak_data <= '0;
         peak_freq <= '0;
      end else begin
         if (accept) cnt <= cnt + 4'd1;
         if (state == WAIT) begin
            if (last_pair) begin
               pair <= '0;
               rnd  <= rnd + 2'd1;
            end else begin
               pair <= pair + 3'd1;
            end
            if (last_cmp) begin
               peak_data <= win_data;
               peak_freq <= win_freq;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         slot_data[cnt] <= in_data;
         slot_freq[cnt] <= cnt;
      end else if (state == WAIT) begin
         slot_data[{1'b0, pair}] <= win_data;
         slot_freq[{1'b0, pair}] <= win_freq;
      end
   end

endmodule
